// File: rtl/bridge_fib_learn.sv
// Forwarding table: learns the source MAC into a direct-mapped table and looks up the destination MAC.
// Optional statistics counters are enabled by defining FIB_STATS_EN.
module bridge_fib_learn #(
    parameter int unsigned table_sz = 1024,
    parameter int unsigned asz      = 10,
    parameter int unsigned pw       = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          lu_srdy,
    output logic          lu_drdy,
    input  logic [47:0]   lu_sa,
    input  logic [47:0]   lu_da,
    input  logic [pw-1:0] lu_port,
    output logic          ls_srdy,
    input  logic          ls_drdy,
    output logic          ls_hit,
    output logic          ls_flood,
    output logic [pw-1:0] ls_port,
    output logic          init_done
`ifdef FIB_STATS_EN
    ,
    output logic [31:0]   stat_hit,
    output logic [31:0]   stat_miss,
    output logic [31:0]   stat_learn
`endif
);

    localparam int unsigned EW = 1 + 48 + pw;
    localparam int unsigned NF = (48 + asz - 1) / asz;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD_SA, S_LEARN, S_RESULT} state_t;

    function automatic logic [asz-1:0] hash(input logic [47:0] x);
        logic [NF*asz-1:0] p;
        logic [asz-1:0]    h;
        p       = '0;
        p[47:0] = x;
        h       = '0;
        for (int unsigned i = 0; i < NF; i++) h ^= p[i*asz +: asz];
        return h;
    endfunction

    state_t          state_q, state_d;
    logic [asz-1:0]  cnt_q, cnt_d;
    logic            init_done_q, init_done_d;
    logic [47:0]     sa_q, sa_d, da_q, da_d;
    logic [pw-1:0]   port_q, port_d;
    logic [EW-1:0]   rd_q, rd_d;
    logic [EW-1:0]   mem [table_sz];

    logic            we, re;
    logic [asz-1:0]  waddr, raddr;
    logic [EW-1:0]   wdata;
    logic            e_valid, hit, in_res;
    logic [47:0]     e_mac;
    logic [pw-1:0]   e_port;

    assign e_valid = rd_q[EW-1];
    assign e_mac   = rd_q[pw +: 48];
    assign e_port  = rd_q[pw-1:0];
    // Group DA never hits, even if the table happens to hold a matching entry.
    assign hit     = e_valid && (e_mac == da_q) && !da_q[40];
    assign in_res  = (state_q == S_RESULT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        sa_d        = sa_q;
        da_d        = da_q;
        port_d      = port_q;
        we          = 1'b0;
        re          = 1'b0;
        waddr       = '0;
        raddr       = '0;
        wdata       = '0;
        case (state_q)
            S_INIT: begin
                we    = 1'b1;
                waddr = cnt_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (lu_srdy) begin
                    sa_d    = lu_sa;
                    da_d    = lu_da;
                    port_d  = lu_port;
                    state_d = S_RD_SA;
                end
            end
            S_RD_SA: begin
                re      = 1'b1;
                raddr   = hash(sa_q);
                state_d = S_LEARN;
            end
            S_LEARN: begin
                we      = !sa_q[40] &&
                          !(e_valid && (e_mac == sa_q) && (e_port == port_q));
                waddr   = hash(sa_q);
                wdata   = {1'b1, sa_q, port_q};
                re      = 1'b1;
                raddr   = hash(da_q);
                state_d = S_RESULT;
            end
            S_RESULT: begin
                if (ls_drdy) state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    // Same-index learn write bypasses into the DA read so sa==da sees the new entry.
    always_comb begin
        rd_d = mem[raddr];
        if (we && (waddr == raddr)) rd_d = wdata;
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rd_q <= rd_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            sa_q        <= '0;
            da_q        <= '0;
            port_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            sa_q        <= sa_d;
            da_q        <= da_d;
            port_q      <= port_d;
        end
    end

    assign lu_drdy   = (state_q == S_IDLE);
    assign ls_srdy   = in_res;
    assign ls_hit    = in_res && hit;
    assign ls_flood  = in_res && !hit;
    assign ls_port   = in_res ? e_port : '0;
    assign init_done = init_done_q;

`ifdef FIB_STATS_EN
    logic [31:0] stat_hit_q, stat_hit_d, stat_miss_q, stat_miss_d, stat_learn_q, stat_learn_d;

    always_comb begin
        stat_hit_d   = stat_hit_q;
        stat_miss_d  = stat_miss_q;
        stat_learn_d = stat_learn_q;
        if (in_res && ls_drdy) begin
            if (hit) stat_hit_d  = stat_hit_q + 32'd1;
            else     stat_miss_d = stat_miss_q + 32'd1;
        end
        if (we && (state_q == S_LEARN)) stat_learn_d = stat_learn_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_hit_q   <= '0;
            stat_miss_q  <= '0;
            stat_learn_q <= '0;
        end else begin
            stat_hit_q   <= stat_hit_d;
            stat_miss_q  <= stat_miss_d;
            stat_learn_q <= stat_learn_d;
        end
    end

    assign stat_hit   = stat_hit_q;
    assign stat_miss  = stat_miss_q;
    assign stat_learn = stat_learn_q;
`endif

endmodule
